ac_sr_multi: RTL and testbench
==============================

Name: ac_sr_multi

Overview:
Parametrised successor of the post-accumulator shift register in the SMAC datapath. It takes bit-serial partial sums (one activation bit per cycle, LSB first) for LANES parallel lanes and reconstructs each lane's weighted total. Activation precision is selected at run time (1..PA_MAX), with unsigned or two's-complement activation modes. A small FSM provides start/stall/abort control and a completion pulse to the DP controller.

Parameters:
M, 16, max partial-sum value per cycle (power of two); per-cycle input width L = $clog2(M)+1
PA_MAX, 8, maximum activation precision in bits
LANES, 4, number of parallel accumulation lanes
W (derived, localparam), $clog2(M)+PA_MAX, per-lane result width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  clean-write: begin new operation with the current sample as bit 0
shift_en  in  1  accept one sample (next activation bit) while accumulating
clear  in  1  abort and zero everything
prec  in  $clog2(PA_MAX)+1  activation precision; sampled on start
signed_mode  in  1  1 = activation is two's complement; sampled on start
inr_ac  in  LANES*L  per-cycle partial sums; lane l at [l*L +: L], unsigned 0..M
outr_ac  out  LANES*W  per-lane results; lane l at [l*W +: W]
out_valid  out  1  one-cycle pulse: outr_ac has just been updated
busy  out  1  high while in ACC

Behaviour:
- One clock (clk); asynchronous active-low reset (rst_n). Reset → state IDLE, outr_ac=0, out_valid=0, busy=0, internal counters/accumulators=0. Reset mid-operation discards it with no out_valid.
- States: IDLE, ACC. busy = (state==ACC).
- Effective precision P = prec, except prec==0 or prec>PA_MAX → P=PA_MAX. Latched with signed_mode on start.
- Priority per cycle: clear > start > shift_en.
- clear: go IDLE, zero accumulators and outr_ac, out_valid=0. Valid in any state.
- start (any state): latch P/mode, discard any in-progress op (no out_valid for it), accept current inr_ac as sample s0, count=1. If P==1, complete this cycle; else go ACC.
- ACC, shift_en=1: accept sample s_count, count++. When the P-th sample is accepted, complete. shift_en=0: hold (stall), indefinitely.
- shift_en in IDLE without start: ignored.
- Completion: next cycle outr_ac lane = Σ_{k=0..P-1} s_k·2^k (unsigned), or the same with the s_{P-1} term weighted −2^(P-1) (signed); out_valid=1 for exactly that cycle; state → IDLE.
- Results are exact in W bits: unsigned max M·(2^PA_MAX−1), signed range −M·2^(PA_MAX−1)..M·(2^(PA_MAX−1)−1), two's complement; no saturation needed. Unsigned results are zero-extended; signed results are sign-extended to W.
- outr_ac changes only on completion, clear or reset. It holds the last result through subsequent IDLE and ACC cycles.
- Latency: out_valid one cycle after the cycle accepting the P-th sample. Back-to-back: start may coincide with the out_valid cycle. That start is accepted normally and does not disturb the pulse.
- Lanes are fully independent arithmetically and share all control.

Test Plan:
- Unsigned, prec=8: lane0 all samples 16 → 4080; lane1 s0=1, rest 0 → 1; lane2 s7=1 only → 128; lane3 zeros → 0. out_valid exactly 8 cycles after start cycle, single pulse.
- Signed, prec=8: lane0 s7=16, others 0 → −2048 (0x800 in W=12); lane1 all 16 → −16; lane2 s0..s6=16, s7=0 → 2032; lane3 s7=1 → −128.
- Precision: prec=4 unsigned lane0 3,0,0,1 → 11. prec=1, start with lane0=5 → 5 with out_valid next cycle. prec=0 → behaves as 8. Signed prec=4 lane0 0,0,0,1 → −8.
- Stall: prec=8 run with shift_en low 3 cycles after s3 → same results as the unstalled run, out_valid 3 cycles later; outr_ac unchanged during the stall.
- Abort: clear after s4 → outr_ac=0, IDLE, no out_valid. start after s4 with new data → only the new op's result, one out_valid. start+clear same cycle → clear wins.
- Reset: rst_n low asynchronously mid-ACC → outputs 0 immediately. After release, shift_en alone is ignored; a fresh start runs correctly.

Source files
------------

// File: rtl/ac_sr_multi.sv
// Multi-lane post-accumulator shift register.
// Rebuilds each lane's weighted total from bit-serial partial sums (LSB first)
// at a run-time precision, with unsigned or two's-complement activations.
module ac_sr_multi #(
  parameter int M      = 16,
  parameter int PA_MAX = 8,
  parameter int LANES  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   shift_en,
  input  logic                                   clear,
  input  logic [$clog2(PA_MAX):0]                prec,
  input  logic                                   signed_mode,
  input  logic [LANES*($clog2(M)+1)-1:0]         inr_ac,
  output logic [LANES*($clog2(M)+PA_MAX)-1:0]    outr_ac,
  output logic                                   out_valid,
  output logic                                   busy
);

  localparam int L  = $clog2(M) + 1;
  localparam int W  = $clog2(M) + PA_MAX;
  localparam int PW = $clog2(PA_MAX) + 1;
  localparam logic [PW-1:0] P_MAX = PW'(PA_MAX);

  typedef enum logic {IDLE, ACC} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic [PW-1:0]   count_q, count_d;
  logic            signed_q, signed_d;
  logic            out_valid_q, out_valid_d;

  logic [PW-1:0]   p_in;
  logic [PW-1:0]   cur_p;
  logic [PW-1:0]   idx;
  logic            accept;
  logic            last;
  logic            neg;

  // Shared control: which sample index is being accepted and whether it is the last one
  always_comb begin
    p_in   = (prec == '0 || prec > P_MAX) ? P_MAX : prec;
    cur_p  = start ? p_in : p_q;
    idx    = start ? '0 : count_q;
    accept = start | ((state_q == ACC) & shift_en);
    last   = (idx == cur_p - 1'b1);
    // The MSB sample of a signed activation carries negative weight
    neg    = (start ? signed_mode : signed_q) & last;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: clear beats start beats shift_en
  always_comb begin
    state_d = state_q;
    if (clear)       state_d = IDLE;
    else if (accept) state_d = last ? IDLE : ACC;
  end

  // Output decode
  always_comb begin
    busy      = (state_q == ACC);
    out_valid = out_valid_q;
  end

  // Next values of latched precision/mode, sample counter and completion pulse
  always_comb begin
    p_d         = p_q;
    signed_d    = signed_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (accept) begin
      if (start) begin
        p_d      = p_in;
        signed_d = signed_mode;
      end
      count_d     = last ? '0 : idx + 1'b1;
      out_valid_d = last;
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= P_MAX;
      signed_q    <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      signed_q    <= signed_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Per-lane datapath: identical arithmetic, shared control
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] outr_q, outr_d;
    logic [W-1:0] term;
    logic [W-1:0] base;
    logic [W-1:0] sum;

    // Weighted add of the current sample; modulo-2^W arithmetic is exact since results fit
    always_comb begin
      term   = W'(inr_ac[gi*L +: L]) << idx;
      base   = start ? '0 : acc_q;
      sum    = neg ? (base - term) : (base + term);
      acc_d  = acc_q;
      outr_d = outr_q;
      if (clear) begin
        acc_d  = '0;
        outr_d = '0;
      end else if (accept) begin
        acc_d = last ? '0 : sum;
        if (last) outr_d = sum;
      end
    end

    // Lane accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q  <= '0;
        outr_q <= '0;
      end else begin
        acc_q  <= acc_d;
        outr_q <= outr_d;
      end
    end

    assign outr_ac[gi*W +: W] = outr_q;
  end

endmodule

// File: tb/tb_ac_sr_multi.sv
// Directed self-checking bench for ac_sr_multi (M=16, PA_MAX=8, LANES=4).
module tb_ac_sr_multi;

  localparam int M = 16, PA_MAX = 8, LANES = 4;
  localparam int L = 5, W = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start, shift_en, clear, signed_mode;
  logic [3:0]           prec;
  logic [LANES*L-1:0]   inr_ac;
  logic [LANES*W-1:0]   outr_ac;
  logic                 out_valid, busy;

  ac_sr_multi #(.M(M), .PA_MAX(PA_MAX), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shift_en(shift_en), .clear(clear),
    .prec(prec), .signed_mode(signed_mode), .inr_ac(inr_ac),
    .outr_ac(outr_ac), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tcount, first_valid, pulses;
  logic [L-1:0] smp [LANES][8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*L-1:0] pack(input int k);
    logic [LANES*L-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*L +: L] = smp[l][k];
    return r;
  endfunction

  function automatic logic [W-1:0] lane(input int l);
    return outr_ac[l*W +: W];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    tcount++;
    if (out_valid) begin
      pulses++;
      if (first_valid < 0) first_valid = tcount;
    end
  endtask

  // Sample patterns
  task automatic fill(input int id);
    for (int k = 0; k < 8; k++)
      for (int l = 0; l < LANES; l++) smp[l][k] = '0;
    for (int k = 0; k < 8; k++) begin
      case (id)
        1: begin
          smp[0][k] = 5'd16;
          smp[1][k] = (k == 0) ? 5'd1 : 5'd0;
          smp[2][k] = (k == 7) ? 5'd1 : 5'd0;
        end
        2: begin
          smp[0][k] = (k == 7) ? 5'd16 : 5'd0;
          smp[1][k] = 5'd16;
          smp[2][k] = (k < 7) ? 5'd16 : 5'd0;
          smp[3][k] = (k == 7) ? 5'd1 : 5'd0;
        end
        default: ;
      endcase
    end
    if (id == 3) begin smp[0][0] = 5'd3; smp[0][3] = 5'd1; end
    if (id == 4) smp[0][0] = 5'd5;
    if (id == 6) smp[0][3] = 5'd1;
  endtask

  // Full operation; optional stall of stall_len cycles before sample stall_at
  task automatic run(input logic [3:0] p_in, input bit sm, input int p_eff,
                     input int stall_at, input int stall_len, input logic [W-1:0] stall_exp);
    tcount = 0; first_valid = -1; pulses = 0;
    start = 1'b1; prec = p_in; signed_mode = sm; inr_ac = pack(0); shift_en = 1'b0;
    tick;
    start = 1'b0;
    for (int k = 1; k < p_eff; k++) begin
      if (k == stall_at) begin
        shift_en = 1'b0;
        inr_ac   = '1;
        for (int s = 0; s < stall_len; s++) begin
          tick;
          check("stall_hold", lane(0), stall_exp);
        end
      end
      shift_en = 1'b1;
      inr_ac   = pack(k);
      tick;
    end
    shift_en = 1'b0;
    inr_ac   = '0;
    repeat (4) tick;
    $display("op prec=%0d signed=%0b latency=%0d pulses=%0d out=%h", p_in, sm, first_valid, pulses, outr_ac);
  endtask

  // Start an op and feed only the first n samples
  task automatic partial(input logic [3:0] p_in, input bit sm, input int n);
    tcount = 0; first_valid = -1; pulses = 0;
    start = 1'b1; prec = p_in; signed_mode = sm; inr_ac = pack(0); shift_en = 1'b0;
    tick;
    start = 1'b0;
    for (int k = 1; k < n; k++) begin
      shift_en = 1'b1;
      inr_ac   = pack(k);
      tick;
    end
    shift_en = 1'b0;
    $display("partial prec=%0d signed=%0b samples=%0d busy=%0b", p_in, sm, n, busy);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; shift_en = 0; clear = 0; signed_mode = 0; prec = '0; inr_ac = '0;
    tcount = 0; first_valid = -1; pulses = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    check("rst_outr", outr_ac[31:0], 32'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Unsigned prec=8
    fill(1);
    tcount = 0; first_valid = -1; pulses = 0;
    start = 1'b1; prec = 4'd8; signed_mode = 1'b0; inr_ac = pack(0);
    tick; start = 1'b0;
    check("busy_acc", busy, 1'b1);
    for (int k = 1; k < 8; k++) begin shift_en = 1'b1; inr_ac = pack(k); tick; end
    shift_en = 1'b0; repeat (3) tick;
    check("u8_lat", first_valid, 8);
    check("u8_pulses", pulses, 1);
    check("u8_l0", lane(0), 4080);
    check("u8_l1", lane(1), 1);
    check("u8_l2", lane(2), 128);
    check("u8_l3", lane(3), 0);
    check("u8_idle", busy, 1'b0);

    // Signed prec=8
    fill(2);
    run(4'd8, 1'b1, 8, 0, 0, '0);
    check("s8_lat", first_valid, 8);
    check("s8_l0", lane(0), 12'h800);
    check("s8_l1", lane(1), 12'hFF0);
    check("s8_l2", lane(2), 2032);
    check("s8_l3", lane(3), 12'hF80);

    // Precision variants
    fill(3);
    run(4'd4, 1'b0, 4, 0, 0, '0);
    check("u4_lat", first_valid, 4);
    check("u4_l0", lane(0), 11);
    fill(4);
    run(4'd1, 1'b0, 1, 0, 0, '0);
    check("p1_lat", first_valid, 1);
    check("p1_l0", lane(0), 5);
    fill(1);
    run(4'd0, 1'b0, 8, 0, 0, '0);
    check("p0_lat", first_valid, 8);
    check("p0_l0", lane(0), 4080);
    check("p0_l2", lane(2), 128);
    fill(6);
    run(4'd4, 1'b1, 4, 0, 0, '0);
    check("s4_l0", lane(0), 12'hFF8);

    // Stall 3 cycles before s4
    fill(1);
    run(4'd8, 1'b0, 8, 4, 3, 12'hFF8);
    check("stall_lat", first_valid, 11);
    check("stall_pulses", pulses, 1);
    check("stall_l0", lane(0), 4080);
    check("stall_l1", lane(1), 1);

    // Clear after s4
    fill(1);
    partial(4'd8, 1'b0, 5);
    clear = 1'b1; tick; clear = 1'b0;
    check("clr_l0", lane(0), 0);
    check("clr_busy", busy, 1'b0);
    repeat (10) tick;
    check("clr_pulses", pulses, 0);

    // Restart after s4 with new data
    fill(1);
    partial(4'd8, 1'b0, 5);
    fill(2);
    run(4'd8, 1'b1, 8, 0, 0, '0);
    check("restart_pulses", pulses, 1);
    check("restart_lat", first_valid, 8);
    check("restart_l0", lane(0), 12'h800);
    check("restart_l2", lane(2), 2032);

    // start and clear together: clear wins
    tcount = 0; first_valid = -1; pulses = 0;
    fill(1);
    start = 1'b1; clear = 1'b1; prec = 4'd8; inr_ac = pack(0);
    tick; start = 1'b0; clear = 1'b0;
    check("sc_busy", busy, 1'b0);
    check("sc_l2", lane(2), 0);
    shift_en = 1'b1;
    repeat (10) tick;
    shift_en = 1'b0;
    check("sc_pulses", pulses, 0);

    // Asynchronous reset mid-operation
    fill(4);
    run(4'd1, 1'b0, 1, 0, 0, '0);
    fill(1);
    partial(4'd8, 1'b0, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_l0", lane(0), 0);
    check("arst_busy", busy, 1'b0);
    check("arst_valid", out_valid, 1'b0);
    #2 rst_n = 1'b1;
    tcount = 0; first_valid = -1; pulses = 0;
    shift_en = 1'b1; inr_ac = pack(0);
    repeat (5) tick;
    shift_en = 1'b0;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_pulses", pulses, 0);
    fill(3);
    run(4'd4, 1'b0, 4, 0, 0, '0);
    check("post_rst_lat", first_valid, 4);
    check("post_rst_l0", lane(0), 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
